accum_seq_checker: RTL and testbench

ACCUM_SEQ_CHECKER -- requirements
Module: accum_seq_checker

---
 rtl/accum_pkg.sv | 17 +
 rtl/accum_exp_pipe.sv | 36 +++
 rtl/accum_seq_checker.sv | 153 +++++++++++++++
 tb/tb_accum_seq_checker.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator sequence checker: parameter defaults and FSM state encoding.
package accum_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP  = 1;
  localparam int DEF_LAT   = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_UP    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/accum_exp_pipe.sv
// Expected-value delay line: LAT register stages, each carrying its own valid bit,
// so an expectation emerges exactly when the accumulator result it predicts does.
module accum_exp_pipe #(
  parameter int LAT = 1,
  parameter int DW  = 33
) (
  input  logic          clk_0,
  input  logic          rstn_0,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data
);

  logic [LAT:1]         vld_pipe;
  logic [LAT:1][DW-1:0] dat_pipe;

  // Shift valid and data one stage per cycle; stage 1 takes the new expectation.
  always_ff @(posedge clk_0 or negedge rstn_0) begin
    if (!rstn_0) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      dat_pipe[1] <= in_data;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[LAT];
  assign out_data = dat_pipe[LAT];

endmodule

// File: rtl/accum_seq_checker.sv
// Drives an external accumulator through an up/down command sequence and checks every
// returned {cout, sum} against an internal model delayed by the accumulator latency.
module accum_seq_checker
  import accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clk_0,
  input  logic             rstn_0,
  input  logic             go_0,
  input  logic [7:0]       up_len_0,
  input  logic [7:0]       down_len_0,
  input  logic [WIDTH-1:0] sum_0,
  input  logic             cout_0,
  output logic             start_stop_0,
  output logic             add_sub_0,
  output logic             busy_0,
  output logic             done_0,
  output logic             pass_0,
  output logic [15:0]      err_cnt_0,
  output logic [WIDTH-1:0] first_err_sum_0
);

  state_t           state, state_nxt;
  logic [7:0]       up_rem, down_rem;
  logic [2:0]       ph_cnt;
  logic [WIDTH-1:0] model, exp_sum;
  logic             exp_cout;
  logic             go_acc, mismatch, exp_vld, done_entry;
  logic [WIDTH:0]   exp_out;

  assign go_acc     = go_0 && (state == ST_IDLE || state == ST_DONE);
  assign done_entry = (state == ST_DRAIN) && (state_nxt == ST_DONE);

  // State register.
  always_ff @(posedge clk_0 or negedge rstn_0) begin
    if (!rstn_0) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and accumulator command outputs; commands are only issued in UP/DOWN.
  always_comb begin
    state_nxt    = state;
    start_stop_0 = 1'b0;
    add_sub_0    = 1'b0;
    busy_0       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (go_acc) state_nxt = ST_SYNC;
      ST_SYNC: begin
        busy_0 = 1'b1;
        if (ph_cnt == 3'd0) begin
          if (up_rem != 8'd0)        state_nxt = ST_UP;
          else if (down_rem != 8'd0) state_nxt = ST_DOWN;
          else                       state_nxt = ST_DRAIN;
        end
      end
      ST_UP: begin
        busy_0       = 1'b1;
        start_stop_0 = 1'b1;
        if (up_rem == 8'd1) state_nxt = (down_rem != 8'd0) ? ST_DOWN : ST_DRAIN;
      end
      ST_DOWN: begin
        busy_0       = 1'b1;
        start_stop_0 = 1'b1;
        add_sub_0    = 1'b1;
        if (down_rem == 8'd1) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_0 = 1'b1;
        if (ph_cnt == 3'd0) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next model value and the carry/borrow the accumulator should report with it.
  always_comb begin
    exp_sum  = model;
    exp_cout = 1'b0;
    if (!add_sub_0) {exp_cout, exp_sum} = {1'b0, model} + (WIDTH+1)'(STEP);
    else begin
      exp_sum  = model - WIDTH'(STEP);
      exp_cout = model < WIDTH'(STEP);
    end
  end

  // Run counters and model: SYNC waits LAT+1 cycles, DRAIN waits LAT cycles, the model
  // is seeded from the accumulator just before the first command.
  always_ff @(posedge clk_0 or negedge rstn_0) begin
    if (!rstn_0) begin
      up_rem   <= '0;
      down_rem <= '0;
      ph_cnt   <= '0;
      model    <= '0;
    end else if (go_acc) begin
      up_rem   <= up_len_0;
      down_rem <= down_len_0;
      ph_cnt   <= 3'(LAT);
    end else begin
      if (state != ST_DRAIN && state_nxt == ST_DRAIN)
        ph_cnt <= 3'(LAT - 1);
      else if ((state == ST_SYNC || state == ST_DRAIN) && ph_cnt != 3'd0)
        ph_cnt <= ph_cnt - 3'd1;
      if (state == ST_SYNC && ph_cnt == 3'd0) model <= sum_0;
      if (state == ST_UP) begin
        up_rem <= up_rem - 8'd1;
        model  <= exp_sum;
      end
      if (state == ST_DOWN) begin
        down_rem <= down_rem - 8'd1;
        model    <= exp_sum;
      end
    end
  end

  accum_exp_pipe #(.LAT(LAT), .DW(WIDTH + 1)) u_exp_pipe (
    .clk_0    (clk_0),
    .rstn_0   (rstn_0),
    .in_vld   (start_stop_0),
    .in_data  ({exp_cout, exp_sum}),
    .out_vld  (exp_vld),
    .out_data (exp_out)
  );

  assign mismatch = exp_vld && ({cout_0, sum_0} != exp_out);

  // Error bookkeeping; pass folds in a mismatch on the final compare, which lands in
  // the same cycle as DONE entry.
  always_ff @(posedge clk_0 or negedge rstn_0) begin
    if (!rstn_0) begin
      err_cnt_0       <= '0;
      first_err_sum_0 <= '0;
      pass_0          <= 1'b0;
      done_0          <= 1'b0;
    end else begin
      done_0 <= done_entry;
      if (go_acc) begin
        err_cnt_0       <= '0;
        first_err_sum_0 <= '0;
        pass_0          <= 1'b0;
      end else begin
        if (mismatch) begin
          if (err_cnt_0 == 16'd0)    first_err_sum_0 <= sum_0;
          if (err_cnt_0 != 16'hFFFF) err_cnt_0 <= err_cnt_0 + 16'd1;
        end
        if (done_entry) pass_0 <= (err_cnt_0 == 16'd0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_accum_seq_checker.sv
// Bench for accum_seq_checker: a behavioural accumulator (with injectable step fault)
// answers the DUT's commands; each run is predicted from the arithmetic trajectory.
module tb_accum_seq_checker;
  import accum_pkg::*;

  localparam int LAT  = DEF_LAT;
  localparam int STEP = DEF_STEP;

  logic        clk = 1'b0;
  logic        rstn_0, go_0, cout_0;
  logic [7:0]  up_len_0, down_len_0;
  logic [31:0] sum_0;
  logic        start_stop_0, add_sub_0, busy_0, done_0, pass_0;
  logic [15:0] err_cnt_0;
  logic [31:0] first_err_sum_0;

  int n_cmp = 0, n_err = 0;
  int n_ss = 0, n_up = 0, n_dn = 0, n_done = 0, n_viol = 0;

  logic        load_req = 1'b0;
  logic [31:0] load_val = '0;
  int          fstep = STEP;
  logic [32:0] apipe [LAT];

  always #5 clk = ~clk;

  accum_seq_checker #(.WIDTH(32), .STEP(STEP), .LAT(LAT)) dut (
    .clk_0(clk), .rstn_0(rstn_0), .go_0(go_0), .up_len_0(up_len_0),
    .down_len_0(down_len_0), .sum_0(sum_0), .cout_0(cout_0),
    .start_stop_0(start_stop_0), .add_sub_0(add_sub_0), .busy_0(busy_0),
    .done_0(done_0), .pass_0(pass_0), .err_cnt_0(err_cnt_0),
    .first_err_sum_0(first_err_sum_0)
  );

  // External accumulator: result visible LAT edges after the command.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < LAT; i++) apipe[i] <= {1'b0, load_val};
    end else begin
      if (start_stop_0) begin
        if (!add_sub_0) apipe[0] <= {1'b0, apipe[0][31:0]} + 33'(fstep);
        else apipe[0] <= {apipe[0][31:0] < 32'(fstep), apipe[0][31:0] - 32'(fstep)};
      end
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign sum_0  = apipe[LAT-1][31:0];
  assign cout_0 = apipe[LAT-1][32];

  // Activity monitor (monotonic counters; runs take differences).
  always @(negedge clk) begin
    if (start_stop_0) begin
      n_ss++;
      if (add_sub_0) n_dn++; else n_up++;
    end
    if (!start_stop_0 && add_sub_0) n_viol++;
    if (done_0) n_done++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ideal trajectory from baseline vs actual accumulator trajectory.
  function automatic void predict(input logic [31:0] b, input int u, input int d, input int f,
                                  output int errs, output logic [31:0] first, output logic [31:0] fin);
    logic [31:0] x, y;
    logic ci, ca;
    errs = 0; first = '0; x = b; y = b;
    for (int k = 0; k < u + d; k++) begin
      if (k < u) begin
        {ci, x} = {1'b0, x} + 33'(STEP);
        {ca, y} = {1'b0, y} + 33'(f);
      end else begin
        ci = x < 32'(STEP); x = x - 32'(STEP);
        ca = y < 32'(f);    y = y - 32'(f);
      end
      if (x != y || ci != ca) begin
        if (errs == 0) first = y;
        errs++;
      end
    end
    fin = y;
  endfunction

  task automatic run(input logic [31:0] b, input int u, input int d, input int f, input bit extra_go);
    int cyc, s_ss, s_up, s_dn, s_done, s_viol, e_err;
    bit seen;
    logic [31:0] e_first, e_fin;
    @(negedge clk); load_val = b; load_req = 1'b1; fstep = f;
    @(negedge clk); load_req = 1'b0;
    s_ss = n_ss; s_up = n_up; s_dn = n_dn; s_done = n_done; s_viol = n_viol;
    go_0 = 1'b1; up_len_0 = 8'(u); down_len_0 = 8'(d);
    @(negedge clk); go_0 = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 600) begin
      @(negedge clk); cyc++;
      if (extra_go && cyc == 3) begin go_0 = 1'b1; up_len_0 = 8'd77; down_len_0 = 8'd9; end
      else go_0 = 1'b0;
      if (done_0) seen = 1;
    end
    go_0 = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    predict(b, u, d, f, e_err, e_first, e_fin);
    chk("latency", 64'(cyc), 64'(2*LAT + 1 + u + d));
    chk("pass", 64'(pass_0), 64'(e_err == 0));
    chk("err_cnt", 64'(err_cnt_0), 64'(e_err));
    chk("first_err", 64'(first_err_sum_0), 64'(e_first));
    chk("final_sum", 64'(sum_0), 64'(e_fin));
    chk("enables", 64'(n_ss - s_ss), 64'(u + d));
    chk("up_cycles", 64'(n_up - s_up), 64'(u));
    chk("down_cycles", 64'(n_dn - s_dn), 64'(d));
    chk("busy_done", 64'(busy_0), 64'd0);
    chk("addsub_idle", 64'(n_viol - s_viol), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done_0), 64'd0);
    chk("done_count", 64'(n_done - s_done), 64'd1);
    chk("pass_hold", 64'(pass_0), 64'(e_err == 0));
  endtask

  initial begin
    int s_done;
    logic [31:0] b;
    rstn_0 = 1'b0; go_0 = 1'b0; up_len_0 = '0; down_len_0 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'({start_stop_0, add_sub_0, busy_0, done_0, pass_0}), 64'd0);
    chk("reset_err", 64'({err_cnt_0, first_err_sum_0}), 64'd0);
    rstn_0 = 1'b1;
    repeat (2) @(negedge clk);

    run(32'd0, 5, 0, 1, 0);              // basic up run
    run(32'd10, 4, 3, 1, 0);             // up then down, ends at 11
    run(32'hFFFF_FFFE, 3, 0, 1, 0);      // wrap through zero with carry
    run(32'd1, 0, 4, 1, 0);              // borrow through zero
    run(32'd100, 3, 0, 2, 0);            // faulty accumulator step
    run(32'd7, 0, 0, 1, 0);              // empty run
    run(32'd50, 12, 2, 1, 1);            // go during UP ignored

    // Reset during UP of a faulty run: outputs drop at once, no done for the aborted run.
    @(negedge clk); load_val = 32'd20; load_req = 1'b1; fstep = 2;
    @(negedge clk); load_req = 1'b0;
    s_done = n_done;
    go_0 = 1'b1; up_len_0 = 8'd12; down_len_0 = 8'd0;
    @(negedge clk); go_0 = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    chk("mid_err_nz", 64'(err_cnt_0 != 16'd0), 64'd1);
    rstn_0 = 1'b0;
    #1;
    chk("abort_outs", 64'({start_stop_0, add_sub_0, busy_0, done_0, pass_0}), 64'd0);
    chk("abort_err", 64'({err_cnt_0, first_err_sum_0}), 64'd0);
    repeat (2) @(negedge clk);
    rstn_0 = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(n_done - s_done), 64'd0);
    run(32'd20, 6, 2, 1, 0);

    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 3))
        0:       b = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        1:       b = 32'($urandom_range(0, 8));
        default: b = $urandom;
      endcase
      run(b, $urandom_range(0, 20), $urandom_range(0, 20),
          ($urandom_range(0, 4) == 0) ? 2 : 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
